// File: rtl/reg_dump_ctrl_pkg.sv
// rtl/reg_dump_ctrl_pkg.sv - shared constants and FSM encoding for the register dump sequencer
package reg_dump_ctrl_pkg;

    localparam int REG_COUNT  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_READ_ENC    = 2'd1;
    localparam logic [1:0] ST_PRESENT_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_READ    = ST_READ_ENC,
        ST_PRESENT = ST_PRESENT_ENC,
        ST_DONE    = ST_DONE_ENC
    } dump_state_t;

endpackage

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - walks a register range through a spare read port and streams index/value words
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        begin a dump (IDLE only) / cancel the running dump
//   readReg, readData   register file read port (read data is combinational from readReg)
//   out_valid/out_ready handshake for the captured word on out_index/out_data
//   busy, done, count   status: not idle, one-cycle completion pulse, words delivered
//
// Build option: REG_DUMP_SKIP_ZERO_EN suppresses words whose value reads as zero.
module reg_dump_ctrl
    import reg_dump_ctrl_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = REG_COUNT - 1,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] readReg,
    input  logic [DATA_W-1:0] readData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic              handshake;
    logic              at_last;
    logic              skip_word;

    // idx parks at FIRST_IDX whenever idle, so it can drive the read port directly
    assign readReg   = idx;
    assign handshake = out_valid & out_ready;
    assign at_last   = (idx == LAST_IDX);

`ifdef REG_DUMP_SKIP_ZERO_EN
    assign skip_word = (readData == '0);
`else
    assign skip_word = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= FIRST_IDX;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            done <= 1'b0;

            // A word accepted in the abort cycle still counts as delivered
            if (handshake) begin
                count <= count + (ADDR_W + 1)'(1);
            end

            if (abort && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                idx       <= FIRST_IDX;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            idx   <= FIRST_IDX;
                            count <= '0;
                            busy  <= 1'b1;
                            state <= ST_READ;
                        end
                    end

                    ST_READ: begin
                        if (skip_word) begin
                            if (at_last) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                idx <= idx + ADDR_W'(1);
                            end
                        end else begin
                            out_data  <= readData;
                            out_index <= idx;
                            out_valid <= 1'b1;
                            state     <= ST_PRESENT;
                        end
                    end

                    ST_PRESENT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (at_last) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                idx   <= idx + ADDR_W'(1);
                                state <= ST_READ;
                            end
                        end
                    end

                    ST_DONE: begin
                        idx   <= FIRST_IDX;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Read-side sequencer for the 32×32 register file. On a start command it walks a configured register range through the file's combinational read port, captures each word, and presents it on a valid/ready stream. The stream carries the register index and value to a debug or trace consumer. It sits beside the datapath and uses a spare read port, so it never writes the register file.

## Interface
- FIRST_REG, 0, first register index dumped
- LAST_REG, 31, last register index dumped; FIRST_REG ≤ LAST_REG ≤ 31
- DATA_W, 32, register word width
- ADDR_W, 5, register index width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a dump; sampled only in IDLE
- abort  in  1  cancel the current dump
- readReg  out  ADDR_W  index driven to the register file read port
- readData  in  DATA_W  register file read data, combinational from readReg
- out_valid  out  1  out_index/out_data hold a captured word
- out_ready  in  1  consumer accepts the word
- out_index  out  ADDR_W  index of the presented word
- out_data  out  DATA_W  value of the presented word
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a dump completes normally
- count  out  ADDR_W+1  words delivered in the current or last dump

## Operation
- FSM states: IDLE, READ, PRESENT, DONE.
- IDLE: readReg=FIRST_REG. On start=1, idx←FIRST_REG, count←0, go to READ.
- READ: readReg=idx. At the edge, out_data←readData, out_index←idx, go to PRESENT.
- PRESENT: out_valid=1. out_index, out_data and readReg stay stable until the handshake.
- On out_valid&out_ready: count++.
  - If idx==LAST_REG, go to DONE.
  - Otherwise idx++, go to READ.
- DONE: done=1 for this one cycle only, then IDLE. count holds until the next start.
- abort=1 in READ, PRESENT or DONE: go to IDLE next edge.
  - out_valid and done drop immediately after that edge.
  - A handshake in the same cycle as abort still increments count.
  - abort has priority over the DONE transition; done is not pulsed.
- start while busy is ignored.
- Register 0 is dumped like any other (reads as the file returns it).

## Timing
- Reset values: state=IDLE, readReg=FIRST_REG, out_valid=0, out_index=0, out_data=0, busy=0, done=0, count=0.
- Reset asserted mid-dump returns the block to IDLE asynchronously. No done pulse.
- start to first out_valid: 2 cycles (IDLE→READ→PRESENT).
- Word-to-word cadence with out_ready held high: 2 cycles per word.
- Full default dump: 64 cycles from start to the done cycle, 32 words.
- out_valid never depends combinationally on out_ready.
- out_ready may be held low for any number of cycles.
- readData must settle within the READ cycle. The file's read path is combinational.

## Configuration
- REG_DUMP_SKIP_ZERO_EN defined:
  - In READ, if readData==0, the word is not presented.
  - If idx==LAST_REG, go to DONE. Otherwise idx++ and stay in READ.
  - count counts only presented words.
  - An all-zero range reaches DONE with count=0 and no out_valid.
- Not defined: every index in range is presented, including zero values.

## Structure
- Shared package: FSM state encoding (2-bit localparams), REG_COUNT=32, default ADDR_W/DATA_W.
- No sub-module is needed; one FSM plus index and count registers.
- Optional sub-module `reg_dump_skid`, a one-entry output holding register, only if the consumer later needs 1-word/cycle throughput.

## Test plan
- Preload R1..R31 with values 0x1000_0000+i. Pulse start, out_ready=1 → 32 words in index order 0..31, R5 data 0x1000_0005, done at cycle 64, count=32.
- Hold out_ready=0 for 5 cycles on index 3 → out_index=3 and out_data stay stable, readReg=3 held, no skipped or duplicated word.
- Assert abort while presenting index 10 with out_ready=0 → IDLE next cycle, out_valid=0, no done pulse, count=10.
- Assert rst asynchronously mid-dump → all outputs at reset values before the next edge; a later start dumps from FIRST_REG.
- Set FIRST_REG=8, LAST_REG=8 → one word, index 8, done pulse, count=1. A start pulse while busy has no effect.
- With REG_DUMP_SKIP_ZERO_EN and only R0, R4 and R31 nonzero → exactly those three words are presented, count=3 (R0 reads as 0, so 2 words if the file holds R0=0).
